// File: rtl/branch_redirect_ctrl.sv
// Redirect/flush sequencer for taken branches and jumps resolved in EX.
// Optional performance counters are enabled with BRANCH_REDIRECT_PERF_EN.
module branch_redirect_ctrl #(
  parameter int ADDR_W        = 32,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken_i,
  input  logic              br_jump_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              hd_stall_i,
  input  logic              mem_stall_i,
  input  logic              if_busy_i,
  output logic              pc_sel_o,
  output logic [ADDR_W-1:0] pc_target_o,
  output logic              flush_ifid_o,
  output logic              flush_idex_o,
  output logic              fetch_discard_o,
  output logic              busy_o,
`ifdef BRANCH_REDIRECT_PERF_EN
  output logic [31:0]       redir_cnt_o,
  output logic [31:0]       jump_cnt_o,
  output logic [31:0]       drain_cyc_o,
`endif
  output logic              timeout_o
);

  // state | meaning
  // IDLE  | no redirect pending, waiting for a taken branch
  // DRAIN | redirect held while the stale in-flight fetch completes
  // REDIR | PC mux selects the latched target until the PC accepts it
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = DRAIN_TIMEOUT[7:0];

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_cap;
  logic [ADDR_W-1:0] r_target;
  logic              r_flush_idex;
  logic [7:0]        r_drain_cnt;
  logic [7:0]        w_drain_inc;
  logic              r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cap           = 1'b0;
    pc_sel_o        = 1'b0;
    flush_ifid_o    = 1'b0;
    fetch_discard_o = 1'b0;
    busy_o          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (br_taken_i && !hd_stall_i && !mem_stall_i) begin
          w_cap       = 1'b1;
          w_state_nxt = if_busy_i ? S_DRAIN : S_REDIR;
        end
      end
      S_DRAIN: begin
        fetch_discard_o = 1'b1;
        flush_ifid_o    = 1'b1;
        busy_o          = 1'b1;
        if (!if_busy_i) w_state_nxt = S_REDIR;
      end
      S_REDIR: begin
        pc_sel_o     = 1'b1;
        flush_ifid_o = 1'b1;
        busy_o       = 1'b1;
        // a frozen pipeline cannot load the PC, so keep selecting the target
        if (!mem_stall_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_drain_inc = (r_drain_cnt == 8'hFF) ? 8'hFF : r_drain_cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target     <= '0;
      r_flush_idex <= 1'b0;
      r_drain_cnt  <= 8'd0;
      r_timeout    <= 1'b0;
    end else begin
      r_flush_idex <= w_cap;
      if (w_cap) r_target <= br_target_i;
      if (r_state == S_DRAIN) begin
        if (w_drain_inc >= TIMEOUT_CNT) r_timeout <= 1'b1;
        r_drain_cnt <= if_busy_i ? w_drain_inc : 8'd0;
      end
    end
  end

  assign pc_target_o  = r_target;
  assign flush_idex_o = r_flush_idex;
  assign timeout_o    = r_timeout;

`ifdef BRANCH_REDIRECT_PERF_EN
  logic [31:0] r_redir_cnt;
  logic [31:0] r_jump_cnt;
  logic [31:0] r_drain_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redir_cnt <= 32'd0;
      r_jump_cnt  <= 32'd0;
      r_drain_cyc <= 32'd0;
    end else begin
      if (w_cap)                r_redir_cnt <= r_redir_cnt + 32'd1;
      if (w_cap && br_jump_i)   r_jump_cnt  <= r_jump_cnt + 32'd1;
      if (r_state == S_DRAIN)   r_drain_cyc <= r_drain_cyc + 32'd1;
    end
  end

  assign redir_cnt_o = r_redir_cnt;
  assign jump_cnt_o  = r_jump_cnt;
  assign drain_cyc_o = r_drain_cyc;
`else
  // jump flag only feeds the statistics counters
  logic w_unused_jump;
  assign w_unused_jump = br_jump_i;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_branch_redirect_ctrl;

  localparam int ADDR_W = 32;
  localparam int DRAIN_TIMEOUT = 16;

  logic              clk;
  logic              rst;
  logic              br_taken_i;
  logic              br_jump_i;
  logic [ADDR_W-1:0] br_target_i;
  logic              hd_stall_i;
  logic              mem_stall_i;
  logic              if_busy_i;
  logic              pc_sel_o;
  logic [ADDR_W-1:0] pc_target_o;
  logic              flush_ifid_o;
  logic              flush_idex_o;
  logic              fetch_discard_o;
  logic              busy_o;
  logic              timeout_o;
`ifdef BRANCH_REDIRECT_PERF_EN
  logic [31:0]       redir_cnt_o;
  logic [31:0]       jump_cnt_o;
  logic [31:0]       drain_cyc_o;
`endif

  branch_redirect_ctrl #(.ADDR_W(ADDR_W), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .br_taken_i      (br_taken_i),
    .br_jump_i       (br_jump_i),
    .br_target_i     (br_target_i),
    .hd_stall_i      (hd_stall_i),
    .mem_stall_i     (mem_stall_i),
    .if_busy_i       (if_busy_i),
    .pc_sel_o        (pc_sel_o),
    .pc_target_o     (pc_target_o),
    .flush_ifid_o    (flush_ifid_o),
    .flush_idex_o    (flush_idex_o),
    .fetch_discard_o (fetch_discard_o),
    .busy_o          (busy_o),
`ifdef BRANCH_REDIRECT_PERF_EN
    .redir_cnt_o     (redir_cnt_o),
    .jump_cnt_o      (jump_cnt_o),
    .drain_cyc_o     (drain_cyc_o),
`endif
    .timeout_o       (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a redirect is either absent, waiting for the stale
  // fetch to return, or offering its target to the PC.
  bit          m_pending;
  bit          m_waiting_fetch;
  int          m_wait_cycles;
  logic [31:0] m_target;
  bit          m_just_captured;
  bit          m_timed_out;
  logic [31:0] m_redirects;
  logic [31:0] m_jumps;
  logic [31:0] m_drain_cycles;

  task automatic model_reset();
    m_pending       = 0;
    m_waiting_fetch = 0;
    m_wait_cycles   = 0;
    m_target        = '0;
    m_just_captured = 0;
    m_timed_out     = 0;
    m_redirects     = '0;
    m_jumps         = '0;
    m_drain_cycles  = '0;
  endtask

  task automatic model_clock(input bit tk, input bit jp, input logic [31:0] tg,
                             input bit hd, input bit ms, input bit bz);
    bit accepted;
    accepted = tk && !hd && !ms && !m_pending;
    if (accepted) begin
      m_target        = tg;
      m_pending       = 1;
      m_waiting_fetch = bz;
      m_wait_cycles   = 0;
      m_redirects     = m_redirects + 1;
      if (jp) m_jumps = m_jumps + 1;
    end else if (m_pending && m_waiting_fetch) begin
      m_drain_cycles = m_drain_cycles + 1;
      if (m_wait_cycles < 255) m_wait_cycles++;
      if (m_wait_cycles >= DRAIN_TIMEOUT) m_timed_out = 1;
      if (!bz) begin
        m_waiting_fetch = 0;
        m_wait_cycles   = 0;
      end
    end else if (m_pending) begin
      if (!ms) m_pending = 0;
    end
    m_just_captured = accepted;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pc_sel",        {31'd0, pc_sel_o},        {31'd0, m_pending && !m_waiting_fetch});
    chk("pc_target",     pc_target_o,              m_target);
    chk("flush_ifid",    {31'd0, flush_ifid_o},    {31'd0, m_pending});
    chk("flush_idex",    {31'd0, flush_idex_o},    {31'd0, m_just_captured});
    chk("fetch_discard", {31'd0, fetch_discard_o}, {31'd0, m_pending && m_waiting_fetch});
    chk("busy",          {31'd0, busy_o},          {31'd0, m_pending});
    chk("timeout",       {31'd0, timeout_o},       {31'd0, m_timed_out});
`ifdef BRANCH_REDIRECT_PERF_EN
    chk("redir_cnt",     redir_cnt_o,              m_redirects);
    chk("jump_cnt",      jump_cnt_o,               m_jumps);
    chk("drain_cyc",     drain_cyc_o,              m_drain_cycles);
`endif
  endtask

  task automatic step(input bit tk, input bit jp, input logic [31:0] tg,
                      input bit hd, input bit ms, input bit bz);
    br_taken_i  = tk;
    br_jump_i   = jp;
    br_target_i = tg;
    hd_stall_i  = hd;
    mem_stall_i = ms;
    if_busy_i   = bz;
    @(posedge clk);
    model_clock(tk, jp, tg, hd, ms, bz);
    #1;
    check_outputs();
  endtask

  task automatic idle_step();
    step(0, 0, 32'h0, 0, 0, 0);
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic apply_reset();
    br_taken_i = 0; br_jump_i = 0; br_target_i = '0;
    hd_stall_i = 0; mem_stall_i = 0; if_busy_i = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    br_taken_i = 0; br_jump_i = 0; br_target_i = '0;
    hd_stall_i = 0; mem_stall_i = 0; if_busy_i = 0;
    @(posedge clk);
    #1;
    apply_reset();
    idle_step();

    // idle fetch: single-cycle redirect
    step(1, 0, 32'h0000_0100, 0, 0, 0);
    chk("idle_fetch_target", pc_target_o, 32'h0000_0100);
    chk("idle_fetch_pcsel", {31'd0, pc_sel_o}, 32'd1);
    idle_step();
    chk("idle_fetch_done", {31'd0, busy_o}, 32'd0);

    // outstanding fetch drains for three cycles
    step(1, 0, 32'h0000_2000, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 0);
    chk("drain_then_pcsel", {31'd0, pc_sel_o}, 32'd1);
    idle_step();
    idle_step();

    // load-use stall defers capture
    step(1, 0, 32'h0000_3000, 1, 0, 0);
    chk("loaduse_no_resp", {31'd0, busy_o}, 32'd0);
    step(1, 0, 32'h0000_3000, 0, 0, 0);
    idle_step();

    // frozen PC during REDIR
    step(1, 1, 32'h0000_4000, 0, 0, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 32'h0, 0, 1, 0);
    chk("frozen_target", pc_target_o, 32'h0000_4000);
    step(0, 0, 32'h0, 0, 0, 0);
    idle_step();

    // back-to-back captures, including one ignored while busy
    step(1, 0, 32'h0000_5000, 0, 0, 0);
    step(1, 0, 32'h0000_6000, 0, 0, 0);
    step(1, 0, 32'h0000_7000, 0, 0, 0);
    idle_step();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1);
    end
    idle_step();

    // three captures, one of them a jump
    apply_reset();
    step(1, 0, 32'h0000_0A00, 0, 0, 0);
    idle_step();
    step(1, 1, 32'h0000_0B00, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 0);
    idle_step();
    step(1, 0, 32'h0000_0C00, 0, 0, 0);
    idle_step();
`ifdef BRANCH_REDIRECT_PERF_EN
    chk("perf_redir_3", redir_cnt_o, 32'd3);
    chk("perf_jump_1",  jump_cnt_o,  32'd1);
`endif

    // drain timeout is sticky and the redirect still completes
    step(1, 0, 32'h0000_8000, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 32'h0, 0, 0, 1);
    chk("timeout_set", {31'd0, timeout_o}, 32'd1);
    step(0, 0, 32'h0, 0, 0, 0);
    chk("timeout_redir", {31'd0, pc_sel_o}, 32'd1);
    idle_step();
    idle_step();
    chk("timeout_sticky", {31'd0, timeout_o}, 32'd1);

    // reset during DRAIN aborts the redirect
    step(1, 0, 32'h0000_9000, 0, 0, 1);
    step(0, 0, 32'h0, 0, 0, 1);
    apply_reset();
    chk("reset_clears_busy", {31'd0, busy_o}, 32'd0);
    for (int i = 0; i < 4; i++) idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Sequences the PC redirect and pipeline flush that follow a taken branch or jump resolved in EX of the RV32I 5-stage core. Latches the resolved target and flushes IF/ID and ID/EX. While an instruction fetch is still outstanding on the memory interface, it holds the redirect and discards the stale fetch. It then drives the PC mux for exactly one accepted cycle. Sits between the EX-stage branch unit, the hazard unit, the IF stage and the PC register.

Parameters:
ADDR_W, 32, width of PC and target.
DRAIN_TIMEOUT, 16, DRAIN-state cycle count at which timeout_o is set (legal range 2..255).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
br_taken_i  in  1  EX-stage branch/jump taken (combinational from branch unit)
br_jump_i  in  1  taken redirect is JAL/JALR (statistics only)
br_target_i  in  ADDR_W  resolved target, already bit0-cleared for JALR
hd_stall_i  in  1  load-use stall from hazard unit
mem_stall_i  in  1  global pipeline freeze (IM/DM wait)
if_busy_i  in  1  IF has a fetch request in flight
pc_sel_o  out  1  PC register loads pc_target_o this cycle
pc_target_o  out  ADDR_W  latched redirect target
flush_ifid_o  out  1  invalidate IF/ID register
flush_idex_o  out  1  invalidate ID/EX register
fetch_discard_o  out  1  drop the instruction returned by the in-flight fetch
busy_o  out  1  controller not IDLE
timeout_o  out  1  sticky drain-timeout flag

Behaviour:
- Reset values:
  - All outputs 0 and pc_target_o = 0.
  - State = IDLE; drain counter = 0.
  - Reset mid-operation aborts any pending redirect; no pc_sel_o pulse follows.
- States: IDLE, DRAIN, REDIR.
- Capture condition cap = br_taken_i & ~hd_stall_i & ~mem_stall_i & (state==IDLE).
  - On cap, register br_target_i into pc_target_o.
  - br_taken_i while state != IDLE is ignored; the instruction is already being flushed.
  - br_taken_i with hd_stall_i or mem_stall_i high is not captured; it is re-evaluated in a later cycle.
- IDLE transitions on cap:
  - if_busy_i=0 at capture: go to REDIR.
  - if_busy_i=1 at capture: go to DRAIN.
- DRAIN:
  - fetch_discard_o=1.
  - Drain counter increments each cycle, saturating at 255.
  - If counter reaches DRAIN_TIMEOUT, set timeout_o=1, held until rst; FSM keeps waiting.
  - When if_busy_i sampled 0: go to REDIR and clear the counter.
- REDIR:
  - pc_sel_o=1.
  - If mem_stall_i=1, stay in REDIR (PC cannot load).
  - Else go to IDLE next cycle. Exactly one non-stalled pc_sel_o cycle per redirect.
- Flush and status outputs (registered, one-cycle latency from cap):
  - flush_idex_o = 1-cycle pulse in the cycle after cap.
  - flush_ifid_o = 1 in every cycle state != IDLE.
  - busy_o = (state != IDLE).
- Back-to-back: a cap can occur in the first cycle back in IDLE, giving a 2-cycle minimum redirect period with no fetch outstanding.
- Target is passed through unmodified; no alignment check.

Optional Feature:
Macro BRANCH_REDIRECT_PERF_EN.
- Defined: adds three 32-bit outputs, each wrapping modulo 2^32 and reset to 0.
  - redir_cnt_o: increments on each cap.
  - jump_cnt_o: increments on cap & br_jump_i.
  - drain_cyc_o: increments each cycle in DRAIN.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Idle fetch: br_taken_i=1, target 0x0000_0100, if_busy_i=0, at cycle N → cycle N+1: flush_idex_o=1, flush_ifid_o=1, pc_sel_o=1, pc_target_o=0x100; cycle N+2: all 0, busy_o=0.
- Outstanding fetch: cap at N with if_busy_i=1 until N+3 → fetch_discard_o=1 N+1..N+3; pc_sel_o=1 at N+4 only; flush_ifid_o=1 N+1..N+4.
- Load-use: br_taken_i=1 with hd_stall_i=1 at N, hd_stall_i=0 at N+1 → no response at N+1; capture at N+1, pc_sel_o=1 at N+2.
- Frozen PC: mem_stall_i=1 during REDIR for 3 cycles → pc_sel_o held 1 for 4 cycles and target stable; single return to IDLE.
- Timeout: if_busy_i stuck 1 for 20 cycles after cap, DRAIN_TIMEOUT=16 → timeout_o rises after 16 DRAIN cycles, stays 1; if_busy_i then drops → REDIR proceeds normally.
- Reset/perf: async rst asserted in DRAIN → outputs 0 immediately, no pc_sel_o afterwards. With BRANCH_REDIRECT_PERF_EN, three caps (one jump) → redir_cnt_o=3, jump_cnt_o=1.
